deskew_registers: RTL and testbench

DESKEW_REGISTERS -- requirements
Module: deskew_registers

---
 rtl/deskew_registers.sv | 122 ++++++++++++
 tb/tb_deskew_registers.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/deskew_registers.sv
// Deskew: lane i is delayed N-1-i advances and then registered, so skewed lanes leave aligned.
// RUN/DRAIN control: a flush forces N more advances so that the last word in flight is pushed out.
module deskew_registers #(
  parameter int DATA_WIDTH = 16,
  parameter int N          = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             en,
  input  logic                             flush,
  input  logic                             in_valid,
  input  logic [N-1:0][DATA_WIDTH-1:0]     din,
  output logic                             adv,
  output logic [N-1:0][DATA_WIDTH-1:0]     dout,
  output logic                             out_valid,
  output logic                             busy,
  output logic                             done,
  output logic [15:0]                      word_cnt
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
  localparam int CW = $clog2(N + 1);

  state_t                          state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic                            done_q, done_d;
  logic [N-2:0]                    vchain_q, vchain_d;
  logic [N-1:0][DATA_WIDTH-1:0]    dout_q, dout_d;
  logic                            out_valid_q, out_valid_d;
  logic [15:0]                     word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0]           tap [N];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    adv     = en;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = DRAIN;
          cnt_d   = CW'(N);
        end
      end
      DRAIN: begin
        adv   = 1'b1;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RUN;
          done_d  = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Per-lane delay line; its last stage feeds the shared output register.
  for (genvar i = 0; i < N - 1; i++) begin : g_lane
    localparam int D = N - 1 - i;
    logic [DATA_WIDTH-1:0] dly_q [D];
    logic [DATA_WIDTH-1:0] dly_d [D];

    always_comb begin
      for (int j = 0; j < D; j++) dly_d[j] = dly_q[j];
      if (adv) begin
        dly_d[0] = din[i];
        for (int j = 1; j < D; j++) dly_d[j] = dly_q[j-1];
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int j = 0; j < D; j++) dly_q[j] <= '0;
      end else begin
        for (int j = 0; j < D; j++) dly_q[j] <= dly_d[j];
      end
    end

    assign tap[i] = dly_q[D-1];
  end

  assign tap[N-1] = din[N-1];

  always_comb begin
    vchain_d = vchain_q;
    dout_d   = dout_q;
    if (adv) begin
      vchain_d[0] = in_valid & (state_q == RUN);
      for (int j = 1; j < N - 1; j++) vchain_d[j] = vchain_q[j-1];
      for (int i = 0; i < N; i++) dout_d[i] = tap[i];
    end
    out_valid_d = adv & vchain_q[N-2];
    word_cnt_d  = word_cnt_q + {15'd0, out_valid_d};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      vchain_q    <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      vchain_q    <= vchain_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign dout      = dout_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == DRAIN);
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_deskew_registers.sv
// Bench for deskew_registers: models the upstream skew from a table indexed by advance count,
// and scoreboards aligned words together with the advance count at which each should emerge.
module tb_deskew_registers;
  localparam int N = 4;
  localparam int W = 16;
  typedef logic [N-1:0][W-1:0] word_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  word_t       din = '0;
  logic        adv;
  word_t       dout;
  logic        out_valid;
  logic        busy;
  logic        done;
  logic [15:0] word_cnt;

  int errors = 0;
  int checks = 0;
  word_t tab [64];
  word_t exp_q [$];
  int    expa_q [$];
  int adv_cnt = 0, last_a = -1, cyc_cnt = 0, ov_cnt = 0, done_cnt = 0, last_ov_cyc = 0;

  deskew_registers #(.DATA_WIDTH(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .in_valid(in_valid),
    .din(din), .adv(adv), .dout(dout), .out_valid(out_valid), .busy(busy),
    .done(done), .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic word_t rnd_word();
    word_t r;
    for (int i = 0; i < N; i++) r[i] = W'($urandom);
    return r;
  endfunction

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (rst_n && adv) adv_cnt <= adv_cnt + 1;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (out_valid) begin
      ov_cnt++;
      last_ov_cyc = cyc_cnt;
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 64'd1, 64'd0);
      end else begin
        check("sb_dout", dout, exp_q.pop_front());
        check("sb_latency", 64'(adv_cnt), 64'(expa_q.pop_front()));
      end
    end
  end

  // One clock of stimulus; lane i sees lane i of the word started i advances ago.
  task automatic cyc(input logic e, input logic f, input logic inj, input word_t w);
    int a = adv_cnt;
    if (a != last_a) begin
      tab[a % 64] = rnd_word();
      last_a = a;
    end
    if (inj) begin
      tab[a % 64] = w;
      exp_q.push_back(w);
      expa_q.push_back(a + N);
    end
    en = e;
    flush = f;
    in_valid = inj;
    for (int i = 0; i < N; i++)
      din[i] = (e || busy) ? tab[(a - i) & 63][i] : W'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic e, input int n);
    for (int k = 0; k < n; k++) cyc(e, 1'b0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    expa_q.delete();
    rst_n = 1'b1;
    ov_cnt = 0;
    done_cnt = 0;
  endtask

  initial begin
    word_t w;
    int t0;
    for (int i = 0; i < 64; i++) tab[i] = rnd_word();

    do_reset();
    check("rst_dout", dout, 64'd0);
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_busy", busy, 64'd0);
    check("rst_done", done, 64'd0);
    check("rst_word_cnt", word_cnt, 64'd0);
    en = 1'b1; #1;
    check("adv_follows_en_hi", adv, 64'd1);
    en = 1'b0; #1;
    check("adv_follows_en_lo", adv, 64'd0);

    // Single word: lane values 1,2,3,4 at advances 0..3.
    w = {16'd4, 16'd3, 16'd2, 16'd1};
    t0 = cyc_cnt;
    cyc(1'b1, 1'b0, 1'b1, w);
    idle(1'b1, 3);
    check("single_dout", dout, w);
    check("single_out_valid", out_valid, 64'd1);
    check("single_word_cnt", word_cnt, 64'd1);
    idle(1'b1, 1);
    check("single_pulse_end", out_valid, 64'd0);
    check("single_pulses", 64'(ov_cnt), 64'd1);
    check("single_latency_cycles", 64'(last_ov_cyc - t0), 64'd4);

    // Back-to-back stream of 8 words.
    do_reset();
    for (int k = 0; k < 8; k++) cyc(1'b1, 1'b0, 1'b1, rnd_word());
    idle(1'b1, 4);
    check("stream_pulses", 64'(ov_cnt), 64'd8);
    check("stream_word_cnt", word_cnt, 64'd8);

    // en pattern 1,0,0,1 mid-word: two stall cycles of extra latency, hold afterwards.
    do_reset();
    w = rnd_word();
    t0 = cyc_cnt;
    cyc(1'b1, 1'b0, 1'b1, w);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    cyc(1'b1, 1'b0, 1'b0, '0);
    idle(1'b0, 3);
    check("stall_latency_cycles", 64'(last_ov_cyc - t0), 64'd6);
    check("stall_dout_held", dout, w);
    check("stall_out_valid_low", out_valid, 64'd0);
    check("stall_pulses", 64'(ov_cnt), 64'd1);
    check("stall_word_cnt", word_cnt, 64'd1);

    // Flush with en=0: N drain cycles, extra flush/en inside drain ignored.
    do_reset();
    w = rnd_word();
    cyc(1'b1, 1'b0, 1'b1, w);
    cyc(1'b0, 1'b1, 1'b0, '0);
    for (int d = 0; d < N; d++) begin
      check("drain_busy", busy, 64'd1);
      check("drain_adv", adv, 64'd1);
      cyc(d == 2, d == 1, 1'b0, '0);
    end
    check("drain_exit_busy", busy, 64'd0);
    check("drain_done", done, 64'd1);
    check("drain_pulses", 64'(ov_cnt), 64'd1);
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("drain_done_clear", done, 64'd0);
    idle(1'b0, 3);
    check("drain_done_once", 64'(done_cnt), 64'd1);
    check("drain_word_cnt", word_cnt, 64'd1);

    // flush and en together with a valid word: one advance, then drain.
    do_reset();
    cyc(1'b1, 1'b1, 1'b1, rnd_word());
    for (int d = 0; d < N; d++) begin
      check("flush_en_busy", busy, 64'd1);
      cyc(1'b0, 1'b0, 1'b0, '0);
    end
    check("flush_en_done", done, 64'd1);
    check("flush_en_pulses", 64'(ov_cnt), 64'd1);

    // Reset in the second drain cycle aborts the drain.
    do_reset();
    cyc(1'b1, 1'b0, 1'b1, rnd_word());
    cyc(1'b0, 1'b1, 1'b0, '0);
    cyc(1'b0, 1'b0, 1'b0, '0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, '0);
    check("abort_dout", dout, 64'd0);
    check("abort_out_valid", out_valid, 64'd0);
    check("abort_busy", busy, 64'd0);
    check("abort_done", done, 64'd0);
    check("abort_word_cnt", word_cnt, 64'd0);
    exp_q.delete();
    expa_q.delete();
    rst_n = 1'b1;
    idle(1'b0, 6);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    check("abort_no_output", 64'(ov_cnt), 64'd0);

    // word_cnt wrap and most-negative lane value.
    do_reset();
    for (int k = 0; k < 65535; k++) cyc(1'b1, 1'b0, 1'b1, rnd_word());
    idle(1'b1, 3);
    check("wrap_pre_cnt", word_cnt, 64'hFFFF);
    w = {16'h8000, 16'h1234, 16'hFFFF, 16'h8000};
    cyc(1'b1, 1'b0, 1'b1, w);
    idle(1'b1, 3);
    check("wrap_dout", dout, w);
    check("wrap_lane0_min", dout[0], 64'h8000);
    check("wrap_word_cnt", word_cnt, 64'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
